// File: rtl/demon_baby_link_pkg.sv
// Shared definitions for the demon_baby nibble-serial command link.
// Used by both the host-side transmitter and the core-side receiver so
// the framing constants and error encodings cannot drift apart.
//   link_state_t   : handshake FSM states
//   SYNC_NIBBLE    : first nibble of every frame
//   FRAME_NIBBLES  : nibbles per frame (sync, 2x opcode, 4x payload, checksum)
//   ERR_*          : err_code values reported by the transmitter
//   frame_checksum : XOR of the seven data-bearing nibbles
package demon_baby_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_HI,
    ST_WAIT_LO
  } link_state_t;

  localparam logic [3:0]  SYNC_NIBBLE   = 4'hA;
  localparam int unsigned FRAME_NIBBLES = 8;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_TO_HI = 2'b01;
  localparam logic [1:0] ERR_TO_LO = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  function automatic logic [3:0] frame_checksum(input logic [7:0]  op,
                                                input logic [15:0] pay);
    return SYNC_NIBBLE ^ op[7:4] ^ op[3:0] ^
           pay[15:12] ^ pay[11:8] ^ pay[7:4] ^ pay[3:0];
  endfunction

endpackage

// File: rtl/demon_baby_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Reused by the receiver for stb; here it brings rx_ack into clk.
//   clk : destination clock
//   rst : synchronous active-high reset, clears the chain to 0
//   d   : asynchronous input
//   q   : synchronized output, SYNC_STAGES cycles behind d
module demon_baby_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/demon_baby_cmd_tx.sv
// Host-side command transmitter for the demon_baby nibble-serial port.
// Frames one opcode+payload command as 8 nibbles (sync, opcode, payload,
// checksum) and sends each with a four-phase stb/ack handshake, aborting
// on a per-phase timeout or on request.
//   clk, rst         : clock, synchronous active-high reset
//   start            : send request, accepted only while busy=0
//   opcode, payload  : command, captured on the accepted start
//   abort            : cancel the frame in progress (ignored when idle)
//   busy             : frame in progress
//   done, err        : one-cycle end-of-frame pulses (success / failure)
//   err_code         : failure cause, held until the next accepted start
//   tx_data, tx_stb  : nibble and strobe driven to the link
//   rx_ack           : asynchronous acknowledge from the receiver
module demon_baby_cmd_tx
  import demon_baby_link_pkg::*;
#(
  parameter int unsigned MAX_COUNT   = 100000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] payload,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [3:0]  tx_data,
  output logic        tx_stb,
  input  logic        rx_ack
);

  localparam int unsigned CNT_W    = $clog2(MAX_COUNT + 1);
  localparam logic [2:0]  LAST_IDX = 3'(FRAME_NIBBLES - 1);

  link_state_t       state;
  logic              setup_phase;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic [7:0]        op_q;
  logic [15:0]       pay_q;
  logic [3:0]        csum_q;
  logic [3:0]        nib;
  logic              ack_s;
  logic              timeout;
  logic              fail_now;
  logic [1:0]        fail_code;

  demon_baby_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_ack),
    .q   (ack_s)
  );

  always_comb begin
    nib = '0;
    case (idx)
      3'd0: nib = SYNC_NIBBLE;
      3'd1: nib = op_q[7:4];
      3'd2: nib = op_q[3:0];
      3'd3: nib = pay_q[15:12];
      3'd4: nib = pay_q[11:8];
      3'd5: nib = pay_q[7:4];
      3'd6: nib = pay_q[3:0];
      3'd7: nib = csum_q;
      default: nib = '0;
    endcase
  end

  // The counter was cleared on entry to the wait state, so the edge that
  // sees MAX_COUNT-1 is the MAX_COUNT-th edge of waiting.
  assign timeout = (wait_cnt == CNT_W'(MAX_COUNT - 1));

  // Abort outranks a same-cycle ack edge or timeout.
  always_comb begin
    fail_now  = 1'b0;
    fail_code = ERR_NONE;
    if (state != ST_IDLE && abort) begin
      fail_now  = 1'b1;
      fail_code = ERR_ABORT;
    end else if (state == ST_WAIT_HI && !ack_s && timeout) begin
      fail_now  = 1'b1;
      fail_code = ERR_TO_HI;
    end else if (state == ST_WAIT_LO && ack_s && timeout) begin
      fail_now  = 1'b1;
      fail_code = ERR_TO_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      setup_phase <= 1'b0;
      idx         <= '0;
      wait_cnt    <= '0;
      op_q        <= '0;
      pay_q       <= '0;
      csum_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      tx_data     <= '0;
      tx_stb      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (fail_now) begin
        tx_stb   <= 1'b0;
        tx_data  <= '0;
        err      <= 1'b1;
        err_code <= fail_code;
        busy     <= 1'b0;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              op_q        <= opcode;
              pay_q       <= payload;
              csum_q      <= frame_checksum(opcode, payload);
              idx         <= '0;
              setup_phase <= 1'b0;
              busy        <= 1'b1;
              err_code    <= ERR_NONE;
              state       <= ST_SETUP;
            end
          end
          // Two cycles: drive the nibble, then raise the strobe, so the
          // data is stable on the link for a full cycle before stb.
          ST_SETUP: begin
            if (!setup_phase) begin
              tx_data     <= nib;
              setup_phase <= 1'b1;
            end else begin
              tx_stb   <= 1'b1;
              wait_cnt <= '0;
              state    <= ST_WAIT_HI;
            end
          end
          ST_WAIT_HI: begin
            if (ack_s) begin
              tx_stb   <= 1'b0;
              wait_cnt <= '0;
              state    <= ST_WAIT_LO;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_WAIT_LO: begin
            if (!ack_s) begin
              if (idx == LAST_IDX) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                idx         <= idx + 3'd1;
                setup_phase <= 1'b0;
                state       <= ST_SETUP;
              end
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demon_baby_cmd_tx.sv
module tb_demon_baby_cmd_tx;

  localparam int unsigned MAXC = 1000;

  logic        clk = 1'b0;
  logic        rst, start, abort, rx_ack;
  logic [7:0]  opcode;
  logic [15:0] payload;
  logic        busy, done, err, tx_stb;
  logic [1:0]  err_code;
  logic [3:0]  tx_data;

  always #5 clk = ~clk;

  demon_baby_cmd_tx #(.MAX_COUNT(MAXC), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opcode   (opcode),
    .payload  (payload),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .tx_data  (tx_data),
    .tx_stb   (tx_stb),
    .rx_ack   (rx_ack)
  );

  // Receiver: 0 = ack follows stb, 1 = never acks,
  // 2 = ack sticks high from nibble 3, 3 = manual ack from nibble 5.
  int unsigned resp_mode;
  logic        manual_ack;
  int unsigned resp_cnt;
  logic        resp_prev_stb;

  always @(negedge clk) begin
    if (!busy) resp_cnt = 0;
    else if (tx_stb && !resp_prev_stb) resp_cnt++;
    resp_prev_stb = tx_stb;
    case (resp_mode)
      0: rx_ack = tx_stb;
      1: rx_ack = 1'b0;
      2: rx_ack = tx_stb | (rx_ack & (resp_cnt >= 4));
      3: rx_ack = (resp_cnt < 6) ? tx_stb : manual_ack;
      default: rx_ack = 1'b0;
    endcase
  end

  int unsigned errors, checks;
  logic        model_busy;
  logic [1:0]  model_code;
  logic [1:0]  exp_end;
  logic [3:0]  frame_nibs [8];
  logic [3:0]  cap [8];
  int unsigned frame_pos;
  logic        prev_stb, rst_prev;
  logic [3:0]  prev_data;
  int unsigned cyc, rise_cyc, fall_cyc, last_lat, done_cnt, err_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
  endtask

  // Frame as a 32-bit word: sync, opcode, payload; nibble 7 is the XOR.
  function automatic logic [3:0] model_nib(input logic [7:0] op, input logic [15:0] pay,
                                           input int unsigned i);
    logic [31:0] word;
    logic [3:0]  x;
    word = {4'hA, op, pay, 4'h0};
    if (i < 7) return word[31 - 4*i -: 4];
    x = 4'h0;
    for (int j = 0; j < 7; j++) x = x ^ word[31 - 4*j -: 4];
    return x;
  endfunction

  task automatic monitor();
    logic end_now, exp_busy;
    int unsigned lat;
    cyc++;
    if (rst) begin
      rst_prev = 1'b1; model_busy = 1'b0; model_code = 2'b00;
      frame_pos = 0; prev_stb = 1'b0; prev_data = 4'h0;
      return;
    end
    if (rst_prev) begin
      rst_prev = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_stb", tx_stb, 0);
      prev_stb = tx_stb; prev_data = tx_data;
    end
    check("done_err_excl", done & err, 0);
    end_now = done | err;
    if (end_now) check("end_while_busy", model_busy, 1);
    exp_busy = model_busy && !end_now;
    check("busy", busy, exp_busy);
    if (tx_stb && !prev_stb) begin
      if (frame_pos < 8) begin
        check("nibble", tx_data, frame_nibs[frame_pos]);
        check("data_setup", tx_data, prev_data);
        cap[frame_pos] = tx_data;
        frame_pos++;
        rise_cyc = cyc;
      end else begin
        check("extra_strobe", frame_pos, 7);
      end
    end else if (tx_stb && prev_stb) begin
      check("data_hold", tx_data, prev_data);
    end
    if (!tx_stb && prev_stb && !err) fall_cyc = cyc;
    if (end_now) check("end_kind", done ? 2'b00 : err_code, exp_end);
    if (done) begin
      done_cnt++;
      check("done_all_nibbles", frame_pos, 8);
    end
    if (err) begin
      err_cnt++;
      check("err_stb_low", tx_stb, 0);
      check("err_data_zero", tx_data, 0);
      if (err_code == 2'b01) begin
        lat = cyc - rise_cyc; last_lat = lat;
        check("timeout_hi_latency", lat, MAXC);
      end else if (err_code == 2'b10) begin
        lat = cyc - fall_cyc; last_lat = lat;
        check("timeout_lo_latency", lat, MAXC);
      end
      model_code = exp_end;
    end else begin
      check("err_code_hold", err_code, model_code);
    end
    model_busy = exp_busy;
    if (start && !exp_busy) begin
      model_busy = 1'b1; model_code = 2'b00; frame_pos = 0;
      for (int i = 0; i < 8; i++) frame_nibs[i] = model_nib(opcode, payload, i);
    end
    prev_stb = tx_stb; prev_data = tx_data;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [15:0] pay, input logic [1:0] kind);
    opcode = op; payload = pay; exp_end = kind; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int unsigned limit);
    int unsigned n;
    n = 0;
    while (!(done || err) && n < limit) begin cycle(); n++; end
    if (!(done || err)) bound_fail(name);
  endtask

  task automatic wait_strobes(input string name, input int unsigned target, input int unsigned limit);
    int unsigned n;
    n = 0;
    while (resp_cnt < target && n < limit) begin cycle(); n++; end
    if (resp_cnt < target) bound_fail(name);
  endtask

  logic [3:0]  exp1 [8];
  int unsigned d0, e0;

  initial begin
    errors = 0; checks = 0; cyc = 0; rise_cyc = 0; fall_cyc = 0; last_lat = 0;
    done_cnt = 0; err_cnt = 0; frame_pos = 0; prev_stb = 1'b0; prev_data = 4'h0;
    rst_prev = 1'b0; model_busy = 1'b0; model_code = 2'b00; exp_end = 2'b00;
    for (int i = 0; i < 8; i++) begin frame_nibs[i] = 4'h0; cap[i] = 4'h0; end
    exp1[0] = 4'hA; exp1[1] = 4'h3; exp1[2] = 4'hC; exp1[3] = 4'hB;
    exp1[4] = 4'hE; exp1[5] = 4'hE; exp1[6] = 4'hF; exp1[7] = 4'h1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; opcode = 8'h00; payload = 16'h0000;
    resp_mode = 0; manual_ack = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // 1: normal frame
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, 16'hBEEF, 2'b00);
    wait_end("t1_wait_done", 300);
    check("t1_done", done, 1);
    check("t1_busy_low", busy, 0);
    repeat (2) cycle();
    for (int i = 0; i < 8; i++) check("t1_seq", cap[i], exp1[i]);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_no_err", err_cnt - e0, 0);

    // abort while idle is ignored
    abort = 1'b1; cycle(); abort = 1'b0;
    repeat (3) cycle();
    check("idle_abort_no_err", err_cnt - e0, 0);

    // 2: receiver never acks
    resp_mode = 1;
    send(8'h55, 16'h1234, 2'b01);
    wait_end("t2_wait_err", 1300);
    check("t2_err", err, 1);
    check("t2_stb_low", tx_stb, 0);
    cycle();
    check("t2_code", err_code, 2'b01);
    check("t2_latency", last_lat, 1000);
    check("t2_busy", busy, 0);

    // 3: ack stuck high from nibble 3
    resp_mode = 2;
    repeat (3) cycle();
    send(8'hA7, 16'h0F0F, 2'b10);
    wait_end("t3_wait_err", 1500);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    cycle();
    check("t3_code", err_code, 2'b10);
    check("t3_latency", last_lat, 1000);
    check("t3_nibbles_sent", frame_pos, 4);
    resp_mode = 0;
    repeat (4) cycle();

    // 4: abort in WAIT_HI of nibble 5, synchronized ack rising the same edge
    d0 = done_cnt;
    resp_mode = 3; manual_ack = 1'b0;
    send(8'h81, 16'hC3D2, 2'b11);
    wait_strobes("t4_wait_nib5", 6, 300);
    manual_ack = 1'b1;
    cycle();
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("t4_err", err, 1);
    check("t4_code", err_code, 2'b11);
    check("t4_stb_low", tx_stb, 0);
    check("t4_no_done", done, 0);
    manual_ack = 1'b0; resp_mode = 0;
    repeat (4) cycle();
    check("t4_done_count", done_cnt - d0, 0);

    // 5: start while busy ignored; start on the done cycle sends a new frame
    d0 = done_cnt;
    send(8'h12, 16'h3456, 2'b00);
    repeat (5) cycle();
    opcode = 8'hFF; payload = 16'hFFFF; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_end("t5_wait_done1", 300);
    check("t5_done1", done, 1);
    check("t5_first_op_hi", cap[1], 4'h1);
    check("t5_first_op_lo", cap[2], 4'h2);
    send(8'h9A, 16'hBCDE, 2'b00);
    check("t5_accepted", busy, 1);
    wait_end("t5_wait_done2", 300);
    check("t5_done2", done, 1);
    cycle();
    check("t5_second_op_hi", cap[1], 4'h9);
    check("t5_second_op_lo", cap[2], 4'hA);
    check("t5_second_csum", cap[7], 4'hD);
    check("t5_done_count", done_cnt - d0, 2);

    // 6: reset during nibble 4, then a clean frame
    e0 = err_cnt;
    send(8'h6B, 16'h2C7E, 2'b00);
    wait_strobes("t6_wait_nib4", 5, 300);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_stb", tx_stb, 0);
    check("t6_data", tx_data, 0);
    check("t6_err", err, 0);
    check("t6_code", err_code, 0);
    check("t6_done", done, 0);
    repeat (3) cycle();
    check("t6_no_err_pulse", err_cnt - e0, 0);
    send(8'h3C, 16'hBEEF, 2'b00);
    wait_end("t6_wait_done", 300);
    check("t6_frame_done", done, 1);
    cycle();
    for (int i = 0; i < 8; i++) check("t6_seq", cap[i], exp1[i]);

    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
